// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a valid/ready output stage and an autonomous scan mode.
// Optional thermometer output is enabled by defining SCAN_DECODER_THERMO_EN (adds port therm).
module scan_decoder #(
    parameter int IN_WIDTH    = 3,
    parameter int OUT_WIDTH   = 8,
    parameter int DWELL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in,
    input  logic [DWELL_WIDTH-1:0] dwell,
`ifdef SCAN_DECODER_THERMO_EN
    input  logic                   therm,
`endif
    output logic [OUT_WIDTH-1:0]   out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err,
    output logic [1:0]             dbg_state
);

    // Handshake: a beat moves on any edge where valid & ready are both high.
    // in_ready never depends on in_valid; out_valid/out hold until out_ready.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DIRECT     = 2'd1,
        SCAN_DRIVE = 2'd2,
        SCAN_WAIT  = 2'd3
    } state_t;

    state_t                 state;
    logic [IN_WIDTH-1:0]    idx;
    logic [IN_WIDTH-1:0]    idx_next;
    logic [DWELL_WIDTH-1:0] cnt;
    logic                   therm_s;
    logic                   accept;
    logic                   in_range;

`ifdef SCAN_DECODER_THERMO_EN
    assign therm_s = therm;
`else
    assign therm_s = 1'b0;
`endif

    // Out-of-range index decodes to all zeros (one-hot) or all ones (thermometer).
    function automatic logic [OUT_WIDTH-1:0] decode(input logic [IN_WIDTH-1:0] ix,
                                                    input logic th);
        logic [OUT_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            r[i] = th ? (IN_WIDTH'(i) <= ix) : (IN_WIDTH'(i) == ix);
        end
        return r;
    endfunction

    assign in_ready  = enable && (state == DIRECT) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign in_range  = ({1'b0, in} < (IN_WIDTH+1)'(OUT_WIDTH));
    assign idx_next  = (idx == IN_WIDTH'(OUT_WIDTH-1)) ? '0 : idx + 1'b1;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
        end else if (!enable) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    err       <= 1'b0;
                    if (mode) begin
                        state <= SCAN_DRIVE;
                        idx   <= '0;
                    end else begin
                        state <= DIRECT;
                    end
                end
                DIRECT: begin
                    if (accept) begin
                        out       <= decode(in, therm_s);
                        out_valid <= 1'b1;
                        err       <= !in_range;
                    end else begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            err       <= 1'b0;
                        end
                        // Leave only once no beat remains held after this edge.
                        if (mode && (!out_valid || out_ready)) begin
                            state <= IDLE;
                        end
                    end
                end
                SCAN_DRIVE: begin
                    err <= 1'b0;
                    if (!out_valid) begin
                        if (!mode) begin
                            state <= IDLE;
                        end else begin
                            out       <= decode(idx, therm_s);
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        if (!mode) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else if (dwell == '0) begin
                            idx <= idx_next;
                            out <= decode(idx_next, therm_s);
                        end else begin
                            out_valid <= 1'b0;
                            cnt       <= dwell;
                            state     <= SCAN_WAIT;
                        end
                    end
                end
                SCAN_WAIT: begin
                    if (!mode) begin
                        state <= IDLE;
                    end else if (cnt <= DWELL_WIDTH'(1)) begin
                        idx       <= idx_next;
                        out       <= decode(idx_next, therm_s);
                        out_valid <= 1'b1;
                        state     <= SCAN_DRIVE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: an 8-line instance and a 6-line instance share all inputs.
// Thermometer checks are compiled in when SCAN_DECODER_THERMO_EN is defined.
module tb_scan_decoder;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_DRIVE  = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       mode;
    logic       in_valid;
    logic [2:0] in_idx;
    logic [7:0] dwell;
    logic       out_ready;
    logic       therm;

    logic       in_ready8, out_valid8, err8;
    logic [7:0] out8;
    logic [1:0] state8;
    logic       in_ready6, out_valid6, err6;
    logic [5:0] out6;
    logic [1:0] state6;

    int total;
    int bad;

    scan_decoder #(.IN_WIDTH(3), .OUT_WIDTH(8), .DWELL_WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .in        (in_idx),
        .dwell     (dwell),
`ifdef SCAN_DECODER_THERMO_EN
        .therm     (therm),
`endif
        .out       (out8),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .err       (err8),
        .dbg_state (state8)
    );

    scan_decoder #(.IN_WIDTH(3), .OUT_WIDTH(6), .DWELL_WIDTH(8)) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready6),
        .in        (in_idx),
        .dwell     (dwell),
`ifdef SCAN_DECODER_THERMO_EN
        .therm     (therm),
`endif
        .out       (out6),
        .out_valid (out_valid6),
        .out_ready (out_ready),
        .err       (err6),
        .dbg_state (state6)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; in_valid = 1'b0;
        in_idx = '0; dwell = '0; out_ready = 1'b0; therm = 1'b0;
        repeat (3) tick();

        check_val("rst_out",       32'(out8),       32'h0);
        check_val("rst_out_valid", 32'(out_valid8), 32'h0);
        check_val("rst_err",       32'(err8),       32'h0);
        check_val("rst_in_ready",  32'(in_ready8),  32'h0);
        check_val("rst_state",     32'(state8),     32'(ST_IDLE));

        // direct streaming
        rst_n = 1'b1; enable = 1'b1; mode = 1'b0; out_ready = 1'b1;
        tick();
        check_val("dir_state", 32'(state8), 32'(ST_DIRECT));
        in_valid = 1'b1; in_idx = 3'd0;
        tick();
        check_val("dir_out0", 32'(out8), 32'h01);
        check_val("dir_ov0",  32'(out_valid8), 32'h1);
        check_val("dir_err0", 32'(err8), 32'h0);
        in_idx = 3'd3;
        tick();
        check_val("dir_out3", 32'(out8), 32'h08);
        in_idx = 3'd7;
        tick();
        check_val("dir_out7", 32'(out8), 32'h80);
        check_val("dir_err7", 32'(err8), 32'h0);
        in_valid = 1'b0;
        tick();
        check_val("dir_drain", 32'(out_valid8), 32'h0);

        // backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_idx = 3'd5;
        tick();
        check_val("bp_out5", 32'(out8), 32'h20);
        check_val("bp_ov5",  32'(out_valid8), 32'h1);
        in_idx = 3'd6;
        #1;
        check_val("bp_in_ready_lo", 32'(in_ready8), 32'h0);
        tick();
        check_val("bp_hold1", 32'(out8), 32'h20);
        check_val("bp_hold_ov", 32'(out_valid8), 32'h1);
        tick();
        check_val("bp_hold2", 32'(out8), 32'h20);
        out_ready = 1'b1; in_idx = 3'd2;
        #1;
        check_val("bp_in_ready_hi", 32'(in_ready8), 32'h1);
        tick();
        check_val("bp_out2", 32'(out8), 32'h04);
        check_val("bp_ov2",  32'(out_valid8), 32'h1);

        // out of range on the 6-line instance
        in_idx = 3'd6;
        tick();
        check_val("oor8_out6", 32'(out8), 32'h40);
        check_val("oor8_err6", 32'(err8), 32'h0);
        check_val("oor6_out6", 32'(out6), 32'h0);
        check_val("oor6_err6", 32'(err6), 32'h1);
        check_val("oor6_ov6",  32'(out_valid6), 32'h1);
        in_idx = 3'd7;
        tick();
        check_val("oor6_out7", 32'(out6), 32'h0);
        check_val("oor6_err7", 32'(err6), 32'h1);
        in_idx = 3'd3;
        tick();
        check_val("oor6_out3", 32'(out6), 32'h08);
        check_val("oor6_err3", 32'(err6), 32'h0);
        in_valid = 1'b0;
        tick();
        check_val("oor_drain", 32'(out_valid8), 32'h0);

        // scan, dwell = 2
        mode = 1'b1; dwell = 8'd2;
        tick();
        check_val("scan_to_idle", 32'(state8), 32'(ST_IDLE));
        tick();
        check_val("scan_enter", 32'(state8), 32'(ST_DRIVE));
        check_val("scan_enter_ov", 32'(out_valid8), 32'h0);
        tick();
        for (int k = 0; k <= 8; k++) begin
            logic [7:0] exp_w;
            exp_w = 8'h01 << (k % 8);
            check_val($sformatf("scan_out%0d", k), 32'(out8), 32'(exp_w));
            check_val($sformatf("scan_ov%0d", k), 32'(out_valid8), 32'h1);
            tick();
            if (k < 8) begin
                check_val($sformatf("scan_gap1_%0d", k), 32'(out_valid8), 32'h0);
                check_val($sformatf("scan_keep_%0d", k), 32'(out8), 32'(exp_w));
                check_val($sformatf("scan_wait_%0d", k), 32'(state8), 32'(ST_WAIT));
                tick();
                check_val($sformatf("scan_gap2_%0d", k), 32'(out_valid8), 32'h0);
                tick();
            end
        end

        // enable drop in SCAN_WAIT
        check_val("en_pre_wait", 32'(state8), 32'(ST_WAIT));
        enable = 1'b0;
        tick();
        check_val("en_state", 32'(state8), 32'(ST_IDLE));
        check_val("en_out",   32'(out8), 32'h0);
        check_val("en_ov",    32'(out_valid8), 32'h0);

        // scan restarts at index 0, dwell = 0 gives one step per cycle
        enable = 1'b1; dwell = 8'd0;
        tick();
        check_val("s0_state", 32'(state8), 32'(ST_DRIVE));
        tick();
        check_val("s0_out0", 32'(out8), 32'h01);
        check_val("s0_ov0",  32'(out_valid8), 32'h1);
        tick();
        check_val("s0_out1", 32'(out8), 32'h02);
        out_ready = 1'b0;
        tick();
        check_val("s0_hold1", 32'(out8), 32'h02);
        check_val("s0_hold_ov", 32'(out_valid8), 32'h1);
        tick();
        check_val("s0_hold2", 32'(out8), 32'h02);
        out_ready = 1'b1;
        tick();
        check_val("s0_out2", 32'(out8), 32'h04);

        // asynchronous reset while a beat is held
        rst_n = 1'b0;
        #1;
        check_val("arst_out",      32'(out8), 32'h0);
        check_val("arst_ov",       32'(out_valid8), 32'h0);
        check_val("arst_in_ready", 32'(in_ready8), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("arst_rel_state", 32'(state8), 32'(ST_DRIVE));
        check_val("arst_rel_ov",    32'(out_valid8), 32'h0);
        tick();
        check_val("arst_rel_out", 32'(out8), 32'h01);
        check_val("arst_rel_ov2", 32'(out_valid8), 32'h1);

`ifdef SCAN_DECODER_THERMO_EN
        mode = 1'b0;
        tick();
        check_val("th_idle", 32'(state8), 32'(ST_IDLE));
        tick();
        therm = 1'b1; in_valid = 1'b1; in_idx = 3'd3;
        tick();
        check_val("th_out3", 32'(out8), 32'h0F);
        in_idx = 3'd7;
        tick();
        check_val("th_out7", 32'(out8), 32'hFF);
        check_val("th_oor6", 32'(out6), 32'h3F);
        check_val("th_err6", 32'(err6), 32'h1);
        in_valid = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
